// File: rtl/keypad_pkg.sv
// Shared types and constants for the 4x4 keypad scanner.
package keypad_pkg;

    // Debounce FSM states
    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        PRESS   = 2'd1,
        HELD    = 2'd2,
        RELEASE = 2'd3
    } kp_state_t;

    // Active-low row strobe for each row select, row[0] first
    localparam logic [0:3] ROW_PAT [0:3] = '{4'b0111, 4'b1011, 4'b1101, 4'b1110};

    // Frame result: 0..15 is a single key code, bit 4 set marks the special results
    localparam logic [4:0] NO_KEY    = 5'h10;
    localparam logic [4:0] MULTI_KEY = 5'h11;

    // Reduce a 16-bit map of low intersections (bit = row*4 + col) to a frame result
    function automatic logic [4:0] classify_frame(input logic [15:0] low_map);
        int         n;
        logic [3:0] code;
        n    = 0;
        code = 4'd0;
        for (int i = 0; i < 16; i++) begin
            if (low_map[i]) begin
                n    = n + 1;
                code = 4'(i);
            end
        end
        if (n == 0)
            return NO_KEY;
        else if (n == 1)
            return {1'b0, code};
        else
            return MULTI_KEY;
    endfunction

endpackage

// File: rtl/keypad_row_scan.sv
// Row strobe generator: holds each row low for T1MS cycles and flags the
// last cycle of every dwell (sample_en) and of every full frame (frame_end).
module keypad_row_scan
    import keypad_pkg::*;
#(
    parameter int T1MS = 100000
) (
    input  logic       CLK,
    input  logic       RST_N,
    output logic [0:3] row,
    output logic [1:0] row_sel,
    output logic       sample_en,
    output logic       frame_end
);

    localparam int CW = (T1MS > 1) ? $clog2(T1MS) : 1;

    logic [CW-1:0] dwell_cnt;

    assign sample_en = (dwell_cnt == CW'(T1MS - 1));
    assign frame_end = sample_en && (row_sel == 2'd3);

    // Dwell counter, row select and registered row strobe advance together
    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            dwell_cnt <= '0;
            row_sel   <= 2'd0;
            row       <= ROW_PAT[0];
        end else if (sample_en) begin
            dwell_cnt <= '0;
            row_sel   <= row_sel + 2'd1;
            row       <= ROW_PAT[row_sel + 2'd1];
        end else begin
            dwell_cnt <= dwell_cnt + 1'b1;
        end
    end

endmodule

// File: rtl/keypad_scan_4x4.sv
// 4x4 matrix keypad scanner with frame-based debounce.
// key_valid is a one-cycle pulse with no ready/backpressure: the consumer must
// take key_code in the pulse cycle; key_code then holds until the next accepted key.
module keypad_scan_4x4
    import keypad_pkg::*;
#(
    parameter int T1MS           = 100000,
    parameter int DEBOUNCE_SCANS = 20
) (
    input  logic       CLK,
    input  logic       RST_N,
    input  logic [0:3] col,
    output logic [0:3] row,
    output logic [3:0] key_code,
    output logic       key_valid,
    output logic       key_down,
    output kp_state_t  dbg_state
);

    localparam int SW = $clog2(DEBOUNCE_SCANS + 1);

    logic [1:0]    row_sel;
    logic          sample_en;
    logic          frame_end;
    logic [0:3]    col_s1;
    logic [0:3]    col_s2;
    logic [3:0]    col_low;
    logic [11:0]   low_acc;
    logic [15:0]   frame_map;
    logic [4:0]    frame_res;
    logic          is_none;
    logic          is_single;

    kp_state_t     state, state_n;
    logic [SW-1:0] stable, stable_n, stable_inc;
    logic [3:0]    cand, cand_n;
    logic [3:0]    code_n;
    logic          valid_n;
    logic          down_n;

    keypad_row_scan #(.T1MS(T1MS)) u_row_scan (
        .CLK       (CLK),
        .RST_N     (RST_N),
        .row       (row),
        .row_sel   (row_sel),
        .sample_en (sample_en),
        .frame_end (frame_end)
    );

    // Two-flop synchronizer for the asynchronous column lines
    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            col_s1 <= 4'b1111;
            col_s2 <= 4'b1111;
        end else begin
            col_s1 <= col;
            col_s2 <= col_s1;
        end
    end

    // Column lines as active-high "pressed" bits, bit c = column c
    always_comb begin
        col_low = 4'b0000;
        for (int c = 0; c < 4; c++) col_low[c] = ~col_s2[c];
    end

    // Keep rows 0..2 of the current frame; row 3 is taken live at frame end
    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            low_acc <= '0;
        end else if (sample_en) begin
            case (row_sel)
                2'd0:    low_acc[3:0]  <= col_low;
                2'd1:    low_acc[7:4]  <= col_low;
                2'd2:    low_acc[11:8] <= col_low;
                default: ;
            endcase
        end
    end

    assign frame_map  = {col_low, low_acc};
    assign frame_res  = classify_frame(frame_map);
    assign is_none    = (frame_res == NO_KEY);
    assign is_single  = ~frame_res[4];
    assign stable_inc = (stable >= SW'(DEBOUNCE_SCANS)) ? stable : stable + 1'b1;

    // Debounce state and output registers
    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            state     <= IDLE;
            stable    <= '0;
            cand      <= 4'd0;
            key_code  <= 4'd0;
            key_valid <= 1'b0;
            key_down  <= 1'b0;
        end else begin
            state     <= state_n;
            stable    <= stable_n;
            cand      <= cand_n;
            key_code  <= code_n;
            key_valid <= valid_n;
            key_down  <= down_n;
        end
    end

    // Next-state and output logic, acting only on frame-end cycles
    always_comb begin
        state_n  = state;
        stable_n = stable;
        cand_n   = cand;
        code_n   = key_code;
        valid_n  = 1'b0;
        down_n   = key_down;
        if (frame_end) begin
            unique case (state)
                IDLE: begin
                    if (is_single) begin
                        state_n  = PRESS;
                        cand_n   = frame_res[3:0];
                        stable_n = SW'(1);
                    end
                end
                PRESS: begin
                    if (is_single && (frame_res[3:0] == cand)) begin
                        stable_n = stable_inc;
                        if (stable_inc == SW'(DEBOUNCE_SCANS)) begin
                            state_n  = HELD;
                            stable_n = '0;
                            code_n   = cand;
                            valid_n  = 1'b1;
                            down_n   = 1'b1;
                        end
                    end else if (is_single) begin
                        cand_n   = frame_res[3:0];
                        stable_n = SW'(1);
                    end else begin
                        state_n  = IDLE;
                        stable_n = '0;
                    end
                end
                HELD: begin
                    if (is_none) begin
                        state_n  = RELEASE;
                        stable_n = SW'(1);
                    end
                end
                RELEASE: begin
                    if (is_none) begin
                        stable_n = stable_inc;
                        if (stable_inc == SW'(DEBOUNCE_SCANS)) begin
                            state_n  = IDLE;
                            stable_n = '0;
                            down_n   = 1'b0;
                        end
                    end else begin
                        state_n  = HELD;
                        stable_n = '0;
                    end
                end
            endcase
        end
    end

    assign dbg_state = state;

endmodule

// File: tb/tb_keypad_scan_4x4.sv
// Bench for keypad_scan_4x4: a keypad model drives the columns from the row
// strobes, and a run-length model of frame results predicts accepted keys.
`timescale 1ns/1ps
module tb_keypad_scan_4x4;
    import keypad_pkg::*;

    localparam int T1MS  = 4;
    localparam int DEB   = 3;
    localparam int FRAME = 4 * T1MS;

    // ---------------- clock / reset ----------------
    logic       CLK   = 1'b0;
    logic       RST_N = 1'b0;
    logic [0:3] col;
    logic [0:3] row;
    logic [3:0] key_code;
    logic       key_valid;
    logic       key_down;
    kp_state_t  dbg_state;

    always #5 CLK = ~CLK;

    keypad_scan_4x4 #(.T1MS(T1MS), .DEBOUNCE_SCANS(DEB)) dut (
        .CLK       (CLK),
        .RST_N     (RST_N),
        .col       (col),
        .row       (row),
        .key_code  (key_code),
        .key_valid (key_valid),
        .key_down  (key_down),
        .dbg_state (dbg_state)
    );

    // Pressed keys, bit r*4+c; a pressed key pulls its column low while its row is strobed
    logic [15:0] keys_q = 16'h0000;

    always_comb begin
        col = 4'b1111;
        for (int r = 0; r < 4; r++)
            if (row[r] == 1'b0)
                for (int c = 0; c < 4; c++)
                    if (keys_q[r*4 + c]) col[c] = 1'b0;
    end

    logic [0:3] row_exp [4] = '{4'b0111, 4'b1011, 4'b1101, 4'b1110};

    // ---------------- scoreboard / model ----------------
    int         n_checks = 0;
    int         n_fail   = 0;
    logic [3:0] exp_q[$];
    logic       m_down  = 1'b0;
    logic       m_valid = 1'b0;
    logic [3:0] m_code  = 4'd0;
    int         run_res = -3;
    int         run_len = 0;

    // Frame result from the pressed set: -1 none, -2 several, else the key index
    function automatic int frame_of(input logic [15:0] k);
        if ($countones(k) == 0) return -1;
        if ($countones(k) > 1) return -2;
        for (int i = 0; i < 16; i++) if (k[i]) return i;
        return -1;
    endfunction

    // A press is accepted when DEB identical single-key frames end while up;
    // a release when DEB empty frames end while down.
    task automatic model_frame(input logic [15:0] k);
        int res;
        res = frame_of(k);
        if (res == run_res) run_len++;
        else begin
            run_res = res;
            run_len = 1;
        end
        m_valid = 1'b0;
        if (!m_down && res >= 0 && run_len == DEB) begin
            m_down  = 1'b1;
            m_valid = 1'b1;
            m_code  = res[3:0];
            exp_q.push_back(res[3:0]);
        end else if (m_down && res == -1 && run_len == DEB) begin
            m_down = 1'b0;
        end
    endtask

    task automatic model_reset();
        m_down  = 1'b0;
        m_valid = 1'b0;
        m_code  = 4'd0;
        run_res = -3;
        run_len = 0;
        exp_q.delete();
    endtask

    // ---------------- driver ----------------
    // Called at the negedge that opens a frame; checks the outputs left by the
    // previous frame, then runs ncyc cycles with the given keys pressed.
    task automatic step_frame(input logic [15:0] keys, input int ncyc);
        logic [3:0] exp;
        keys_q = keys;
        n_checks++;
        if (key_valid !== m_valid) begin
            n_fail++;
            $display("FAIL key_valid: got %b expected %b at %0t", key_valid, m_valid, $time);
        end
        n_checks++;
        if (key_down !== m_down) begin
            n_fail++;
            $display("FAIL key_down: got %b expected %b at %0t", key_down, m_down, $time);
        end
        n_checks++;
        if (key_code !== m_code) begin
            n_fail++;
            $display("FAIL key_code: got %0d expected %0d at %0t", key_code, m_code, $time);
        end
        if (key_valid === 1'b1) begin
            n_checks++;
            if (exp_q.size() == 0) begin
                n_fail++;
                $display("FAIL spurious_event: got code %0d expected no event at %0t", key_code, $time);
            end else begin
                exp = exp_q.pop_front();
                if (key_code !== exp) begin
                    n_fail++;
                    $display("FAIL event_code: got %0d expected %0d at %0t", key_code, exp, $time);
                end
            end
        end
        for (int i = 0; i < ncyc; i++) begin
            n_checks++;
            if (row !== row_exp[i/4]) begin
                n_fail++;
                $display("FAIL row_strobe: got %b expected %b at %0t", row, row_exp[i/4], $time);
            end
            if (i > 0) begin
                n_checks++;
                if (key_valid !== 1'b0) begin
                    n_fail++;
                    $display("FAIL pulse_width: got key_valid %b expected 0 at %0t", key_valid, $time);
                end
            end
            @(negedge CLK);
        end
        if (ncyc == FRAME) model_frame(keys);
    endtask

    task automatic check_cleared(input string tag);
        n_checks++;
        if (row !== 4'b0111 || key_code !== 4'd0 || key_valid !== 1'b0 ||
            key_down !== 1'b0 || dbg_state !== IDLE) begin
            n_fail++;
            $display("FAIL %s: got row=%b code=%0d valid=%b down=%b state=%0d expected row=0111 code=0 valid=0 down=0 state=0",
                     tag, row, key_code, key_valid, key_down, dbg_state);
        end
    endtask

    // ---------------- tests ----------------
    task automatic test_reset();
        RST_N  = 1'b0;
        keys_q = 16'h0000;
        repeat (3) @(negedge CLK);
        check_cleared("reset_state");
        model_reset();
        RST_N = 1'b1;
    endtask

    task automatic test_scan_idle();
        repeat (2) step_frame(16'h0000, FRAME);
    endtask

    task automatic test_single_press();
        repeat (6) step_frame(16'h0200, FRAME);
        n_checks++;
        if (key_code !== 4'd9 || key_down !== 1'b1) begin
            n_fail++;
            $display("FAIL held_key9: got code=%0d down=%b expected code=9 down=1", key_code, key_down);
        end
        repeat (3) step_frame(16'h0000, FRAME);
    endtask

    task automatic test_bounce();
        for (int f = 0; f < 10; f++) step_frame((f % 2 == 0) ? 16'h0200 : 16'h0000, FRAME);
        repeat (2) step_frame(16'h0000, FRAME);
    endtask

    task automatic test_multi();
        repeat (6) step_frame(16'h0210, FRAME);
        repeat (4) step_frame(16'h0200, FRAME);
        repeat (3) step_frame(16'h0000, FRAME);
    endtask

    task automatic test_release_glitch();
        repeat (3) step_frame(16'h0200, FRAME);
        step_frame(16'h0000, FRAME);
        step_frame(16'h0200, FRAME);
        repeat (3) step_frame(16'h0000, FRAME);
        step_frame(16'h0000, FRAME);
        n_checks++;
        if (key_code !== 4'd9 || key_down !== 1'b0) begin
            n_fail++;
            $display("FAIL code_after_release: got code=%0d down=%b expected code=9 down=0", key_code, key_down);
        end
    endtask

    task automatic test_reset_mid();
        step_frame(16'h0200, FRAME);
        step_frame(16'h0200, 6);
        RST_N = 1'b0;
        #1;
        check_cleared("reset_mid_press");
        model_reset();
        @(negedge CLK);
        @(negedge CLK);
        RST_N = 1'b1;
        repeat (5) step_frame(16'h0200, FRAME);
        repeat (3) step_frame(16'h0000, FRAME);
    endtask

    task automatic test_random();
        logic [15:0] k;
        int          hold;
        int          a;
        int          b;
        for (int s = 0; s < 40; s++) begin
            case ($urandom_range(0, 3))
                0: k = 16'h0000;
                3: begin
                    a = $urandom_range(0, 15);
                    b = (a + $urandom_range(1, 15)) % 16;
                    k = 16'h0000;
                    k[a] = 1'b1;
                    k[b] = 1'b1;
                end
                default: begin
                    k = 16'h0000;
                    k[$urandom_range(0, 15)] = 1'b1;
                end
            endcase
            hold = $urandom_range(1, 5);
            repeat (hold) step_frame(k, FRAME);
        end
        repeat (4) step_frame(16'h0000, FRAME);
    endtask

    initial begin
        #2ms;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        test_reset();
        test_scan_idle();
        test_single_press();
        test_bounce();
        test_multi();
        test_release_glitch();
        test_reset_mid();
        test_random();
        step_frame(16'h0000, FRAME);
        n_checks++;
        if (exp_q.size() != 0) begin
            n_fail++;
            $display("FAIL missing_events: got %0d unconsumed expected 0", exp_q.size());
        end
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
